cast_vc_credit_scheduler: RTL and testbench

Per-output-port virtual-channel scheduler for the cast router's credit-based flow-control variant. It shares one physical output link between VN per-VC crossbar outputs, granting one flit per cycle round-robin among VCs that both have a flit and hold a downstream buffer credit. It tracks per-VC credit counters against downstream input-buffer depth and registers the selected flit onto the link with a one-hot VC tag. One instance sits at each of the PN output ports, in place of ready-based output arbitration.

---
 rtl/cast_pkg.sv | 21 ++
 rtl/cast_rr_arbiter.sv | 39 +++
 rtl/cast_vc_credit_scheduler.sv | 77 +++++++
 tb/tb_cast_vc_credit_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cast_pkg.sv
// rtl/cast_pkg.sv - shared VC types and helpers for the cast router schedulers
`ifndef VN
`define VN 4
`endif
`ifndef DW
`define DW 32
`endif

package cast_pkg;

   typedef logic [`VN-1:0] vc_onehot_t;

   function automatic int credit_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic vc_onehot_t onehot(input int idx);
      return vc_onehot_t'(1) << idx;
   endfunction

endpackage

// File: rtl/cast_rr_arbiter.sv
// rtl/cast_rr_arbiter.sv - round-robin arbiter with registered search pointer
module cast_rr_arbiter #(
   parameter int N = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] rr_ptr
);

   logic          found;
   logic [PW-1:0] nxt_ptr;

   // Search begins at rr_ptr and wraps; the winner's successor becomes the next start.
   always_comb begin
      gnt     = '0;
      found   = 1'b0;
      nxt_ptr = rr_ptr;
      for (int i = 0; i < N; i++) begin
         if (!found && req[(int'(rr_ptr) + i) % N]) begin
            found                         = 1'b1;
            gnt[(int'(rr_ptr) + i) % N]   = 1'b1;
            nxt_ptr                       = PW'((int'(rr_ptr) + i + 1) % N);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (en && found) begin
         rr_ptr <= nxt_ptr;
      end
   end

endmodule

// File: rtl/cast_vc_credit_scheduler.sv
// rtl/cast_vc_credit_scheduler.sv - credit-based VC scheduler for one output link
module cast_vc_credit_scheduler
   import cast_pkg::*;
#(
   parameter int VN        = `VN,
   parameter int DW        = `DW,
   parameter int BUF_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] data_i  [VN],
   input  logic          valid_i [VN],
   output logic          ready_o [VN],
   input  logic [VN-1:0] credit_i,
   output logic [VN-1:0] vc_o,
   output logic [DW-1:0] data_o,
   output logic          valid_o,
   output logic          err_o
);

   localparam int            CW   = credit_w(BUF_DEPTH);
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);
   localparam int            PW   = (VN > 1) ? $clog2(VN) : 1;

   logic [CW-1:0] cnt [VN];
   logic [VN-1:0] eligible;
   logic [VN-1:0] gnt;
   logic [PW-1:0] rr_ptr;
   logic [DW-1:0] sel_data;

   always_comb begin
      eligible = '0;
      sel_data = '0;
      for (int v = 0; v < VN; v++) begin
         eligible[v] = valid_i[v] && (cnt[v] != '0);
         ready_o[v]  = gnt[v];
         sel_data    = sel_data | (data_i[v] & {DW{gnt[v]}});
      end
   end

   cast_rr_arbiter #(.N(VN)) u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (eligible),
      .en     (1'b1),
      .gnt    (gnt),
      .rr_ptr (rr_ptr)
   );

   assert property (@(posedge clk) disable iff (rst) int'(rr_ptr) < VN);

   // A grant consumes a credit and a returned credit restores one; both together cancel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o <= 1'b0;
         vc_o    <= '0;
         data_o  <= '0;
         err_o   <= 1'b0;
         for (int v = 0; v < VN; v++) cnt[v] <= FULL;
      end else begin
         valid_o <= |gnt;
         vc_o    <= gnt;
         if (|gnt) data_o <= sel_data;
         for (int v = 0; v < VN; v++) begin
            case ({gnt[v], credit_i[v]})
               2'b10:   cnt[v] <= cnt[v] - 1'b1;
               2'b01: begin
                  if (cnt[v] == FULL) err_o  <= 1'b1;
                  else                cnt[v] <= cnt[v] + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cast_vc_credit_scheduler.sv
// tb/tb_cast_vc_credit_scheduler.sv - scoreboard bench for the credit VC scheduler
module tb_cast_vc_credit_scheduler;
   import cast_pkg::*;

   localparam int VN = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] data_i  [VN];
   logic          valid_i [VN];
   logic          ready_o [VN];
   logic [VN-1:0] credit_i;
   logic [VN-1:0] vc_o;
   logic [DW-1:0] data_o;
   logic          valid_o;
   logic          err_o;

   typedef struct packed {
      logic [VN-1:0] vc;
      logic [DW-1:0] data;
   } flit_t;

   flit_t exp_q[$];
   int    checks = 0;
   int    errors = 0;

   always #5 clk = ~clk;

   cast_vc_credit_scheduler #(.VN(VN), .DW(DW), .BUF_DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .credit_i (credit_i),
      .vc_o     (vc_o),
      .data_o   (data_o),
      .valid_o  (valid_o),
      .err_o    (err_o)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic expect_flit(input int vc, input logic [DW-1:0] d);
      flit_t f;
      f.vc   = onehot(vc);
      f.data = d;
      exp_q.push_back(f);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int v = 0; v < VN; v++) begin
         valid_i[v] = 1'b0;
         data_i[v]  = '0;
      end
      credit_i = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin : monitor
      flit_t f;
      forever begin
         @(negedge clk);
         if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_flit actual vc=%0h data=%0h required=none", vc_o, data_o);
            end else begin
               f = exp_q.pop_front();
               check("flit_vc", vc_o, f.vc);
               check("flit_data", data_o, f.data);
            end
         end
      end
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst = 1'b1;
      clear_inputs();
      for (int v = 0; v < VN; v++) begin
         valid_i[v] = 1'b1;
         data_i[v]  = 32'h10 + v;
      end
      repeat (3) begin
         @(negedge clk);
         check("rst_valid", valid_o, 0);
         check("rst_vc", vc_o, 0);
         check("rst_err", err_o, 0);
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < VN; k++) begin
         expect_flit(k, 32'h10 + k);
         step();
         valid_i[k] = 1'b0;
      end

      // credit exhaustion on VC2
      do_reset();
      valid_i[2] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         data_i[2] = 32'hA0 + k;
         expect_flit(2, 32'hA0 + k);
         step();
      end
      data_i[2] = 32'hA4;
      check("exhaust_ready", ready_o[2], 0);
      step();
      check("exhaust_hold", ready_o[2], 0);
      credit_i[2] = 1'b1;
      check("credit_same_cycle", ready_o[2], 0);
      step();
      credit_i = '0;
      check("credit_next_cycle", ready_o[2], 1);
      expect_flit(2, 32'hA4);
      step();
      data_i[2] = 32'hA5;
      check("reexhaust_ready", ready_o[2], 0);
      valid_i[2] = 1'b0;

      // fairness with credits returned two cycles after each grant
      do_reset();
      for (int v = 0; v < VN; v++) begin
         valid_i[v] = 1'b1;
         data_i[v]  = 32'hC000 + v * 256;
      end
      for (int k = 0; k < 12; k++) begin
         credit_i = (k >= 2) ? onehot((k - 2) % VN) : '0;
         expect_flit(k % VN, data_i[k % VN]);
         step();
         check("fair_nogap", valid_o, 1);
         data_i[k % VN] = data_i[k % VN] + 1;
      end
      clear_inputs();

      // grant and credit on VC1 in the same cycle at cnt=1
      do_reset();
      valid_i[1] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         data_i[1] = 32'hB0 + k;
         expect_flit(1, 32'hB0 + k);
         step();
      end
      data_i[1]   = 32'hB3;
      credit_i[1] = 1'b1;
      check("gc_ready", ready_o[1], 1);
      expect_flit(1, 32'hB3);
      step();
      credit_i = '0;
      data_i[1] = 32'hB4;
      valid_i[0] = 1'b1; data_i[0] = 32'hD0;
      valid_i[2] = 1'b1; data_i[2] = 32'hD2;
      valid_i[3] = 1'b1; data_i[3] = 32'hD3;
      expect_flit(2, 32'hD2);
      step();
      valid_i[2] = 1'b0;
      expect_flit(3, 32'hD3);
      step();
      valid_i[3] = 1'b0;
      expect_flit(0, 32'hD0);
      step();
      valid_i[0] = 1'b0;
      expect_flit(1, 32'hB4);
      step();
      data_i[1] = 32'hB5;
      check("gc_exact_cnt", ready_o[1], 0);
      valid_i[1] = 1'b0;

      // credit overflow on idle VC3
      do_reset();
      check("ovf_pre", err_o, 0);
      credit_i[3] = 1'b1;
      step();
      credit_i = '0;
      check("ovf_set", err_o, 1);
      repeat (3) step();
      check("ovf_sticky", err_o, 1);
      valid_i[3] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         data_i[3] = 32'hE0 + k;
         expect_flit(3, 32'hE0 + k);
         step();
      end
      data_i[3] = 32'hE4;
      check("ovf_saturated", ready_o[3], 0);
      valid_i[3] = 1'b0;

      // asynchronous reset while a flit is on the link
      valid_i[0] = 1'b1;
      data_i[0]  = 32'hF0;
      expect_flit(0, 32'hF0);
      step();
      valid_i[0] = 1'b0;
      @(negedge clk);
      #1;
      check("mid_pre_valid", valid_o, 1);
      rst = 1'b1;
      #1;
      check("mid_valid", valid_o, 0);
      check("mid_vc", vc_o, 0);
      check("mid_data", data_o, 0);
      check("mid_err", err_o, 0);
      valid_i[0] = 1'b1; data_i[0] = 32'h60;
      valid_i[1] = 1'b1; data_i[1] = 32'h70;
      @(posedge clk);
      #1 rst = 1'b0;
      expect_flit(0, 32'h60);
      step();
      data_i[0] = 32'h61;
      expect_flit(1, 32'h70);
      step();
      valid_i[1] = 1'b0;
      for (int k = 1; k < 4; k++) begin
         expect_flit(0, 32'h60 + k);
         step();
         data_i[0] = 32'h61 + k;
      end
      check("rst_cnt_full", ready_o[0], 0);
      valid_i[0] = 1'b0;

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
